// File: rtl/peridot_tx_packet_encoder.sv
// ---------------------------------------------------------------------------
// peridot_tx_packet_encoder
//
// Turns a stream of packet beats (one data byte each, with start/end flags)
// into a flat byte stream for a UART-style sender. Each accepted beat is
// emitted as:
//   [SOP_MARK if sop] [EOP_MARK if eop] payload
// The payload is the data byte itself, or ESC_MARK followed by
// (data ^ ESC_XOR) when the data byte collides with one of the four marker
// values. This lets the far end re-frame the stream.
//
// Ports
//   clk              : single clock, rising edge
//   reset            : synchronous, active-high
//   in_ready         : beat sink ready (combinational from out_ready)
//   in_valid         : beat valid
//   in_data[7:0]     : beat data byte
//   in_startofpacket : beat is first of packet
//   in_endofpacket   : beat is last of packet
//   out_ready        : downstream sender ready
//   out_valid        : encoded byte valid (registered)
//   out_data[7:0]    : encoded byte (registered)
// ---------------------------------------------------------------------------
module peridot_tx_packet_encoder #(
  parameter logic [7:0] SOP_MARK = 8'h7A,
  parameter logic [7:0] EOP_MARK = 8'h7B,
  parameter logic [7:0] CH_MARK  = 8'h7C,
  parameter logic [7:0] ESC_MARK = 8'h7D,
  parameter logic [7:0] ESC_XOR  = 8'h20
) (
  input  logic       clk,
  input  logic       reset,
  output logic       in_ready,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_startofpacket,
  input  logic       in_endofpacket,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data
);

  // Each non-IDLE state names the next byte still owed for the held beat.
  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    EMIT_EOP      = 2'd1,
    EMIT_ESC_DATA = 2'd2,
    EMIT_DATA     = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_next_state;

  // Holding registers for the beat being expanded.
  logic       r_eop;
  logic       r_special;
  logic [7:0] r_data;     // already XORed when r_special is set

  // Registered output slot.
  logic       r_out_valid;
  logic [7:0] r_out_data;

  logic       w_slot_free;
  logic       w_accept;
  logic       w_in_special;
  logic [7:0] w_in_payload;
  state_t     w_payload_state;   // state that emits the payload of the incoming beat
  state_t     w_held_payload_st; // same, for the held beat
  logic       w_load;
  logic [7:0] w_byte;

  // -------------------------------------------------------------------------
  // Handshake and beat classification
  // -------------------------------------------------------------------------
  assign w_slot_free = !r_out_valid || out_ready;

  // in_ready depends combinationally on out_ready; this keeps full
  // throughput for plain beats without a skid buffer.
  assign in_ready = (r_state == IDLE) && w_slot_free;
  assign w_accept = in_valid && in_ready;

  assign w_in_special = (in_data == SOP_MARK) || (in_data == EOP_MARK) ||
                        (in_data == CH_MARK)  || (in_data == ESC_MARK);
  assign w_in_payload = w_in_special ? (in_data ^ ESC_XOR) : in_data;

  assign w_payload_state   = w_in_special ? EMIT_ESC_DATA : EMIT_DATA;
  assign w_held_payload_st = r_special    ? EMIT_ESC_DATA : EMIT_DATA;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          // The first byte goes out on the accept edge; move to the state
          // of the byte that follows it, if any.
          if (in_startofpacket)
            w_next_state = in_endofpacket ? EMIT_EOP : w_payload_state;
          else if (in_endofpacket)
            w_next_state = w_payload_state;
          else if (w_in_special)
            w_next_state = EMIT_DATA;   // ESC_MARK sent now, data next
          else
            w_next_state = IDLE;        // single-byte sequence
        end
      end
      EMIT_EOP:      if (w_slot_free) w_next_state = w_held_payload_st;
      EMIT_ESC_DATA: if (w_slot_free) w_next_state = EMIT_DATA;
      EMIT_DATA:     if (w_slot_free) w_next_state = IDLE;
      default:       w_next_state = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs (which byte, if any, enters the output slot this edge)
  // -------------------------------------------------------------------------
  always_comb begin
    w_load = 1'b0;
    w_byte = 8'h00;
    unique case (r_state)
      IDLE: begin
        w_load = w_accept;
        if (in_startofpacket)   w_byte = SOP_MARK;
        else if (in_endofpacket) w_byte = EOP_MARK;
        else if (w_in_special)   w_byte = ESC_MARK;
        else                     w_byte = in_data;
      end
      EMIT_EOP: begin
        w_load = w_slot_free;
        w_byte = EOP_MARK;
      end
      EMIT_ESC_DATA: begin
        w_load = w_slot_free;
        w_byte = ESC_MARK;
      end
      EMIT_DATA: begin
        w_load = w_slot_free;
        w_byte = r_data;
      end
      default: begin
        w_load = 1'b0;
        w_byte = 8'h00;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output slot: a byte stays put until it transfers; valid only drops when
  // the slot frees up with nothing new to load.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= 8'h00;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_byte;
    end else if (w_slot_free) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  // -------------------------------------------------------------------------
  // Holding registers, captured on accept. Reset clears them so a beat that
  // was mid-expansion is dropped rather than resumed.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_eop     <= 1'b0;
      r_special <= 1'b0;
      r_data    <= 8'h00;
    end else if (w_accept) begin
      r_eop     <= in_endofpacket;
      r_special <= w_in_special;
      r_data    <= w_in_payload;
    end
  end

  // EMIT_EOP is only reachable for a beat that carried eop.
  a_eop_state: assert property (@(posedge clk) disable iff (reset)
    (r_state == EMIT_EOP) |-> r_eop);

endmodule
